// File: rtl/capp_sequencer.sv
// capp_sequencer: single-op command front-end for the CAPP array.
// Accepts one micro-op, drives a one-cycle CAPP strobe, waits SETTLE_CYCLES,
// then optionally samples the CAPP outputs into a held response.
// Optional build macro: CAPP_SEQ_POPCOUNT_EN (STATUS returns the tag popcount).
module capp_sequencer #(
    parameter int unsigned num_bits      = 32,
    parameter int unsigned num_cells     = 100,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [num_bits-1:0]   instr_data,
    input  logic [num_bits-1:0]   instr_mask,
    output logic [num_bits-1:0]   comparand,
    output logic [num_bits-1:0]   mask,
    output logic                  perform_search,
    output logic                  set,
    output logic                  select_first,
    output logic [2*num_bits-1:0] write_lines,
    input  logic [num_cells-1:0]  tag_wires,
    input  logic [num_bits-1:0]   read_lines,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [num_bits-1:0]   rsp_data,
    output logic                  rsp_any,
    output logic                  rsp_err
);

    localparam logic [2:0] OpNop    = 3'd0;
    localparam logic [2:0] OpSearch = 3'd1;
    localparam logic [2:0] OpSet    = 3'd2;
    localparam logic [2:0] OpSelFst = 3'd3;
    localparam logic [2:0] OpWrite  = 3'd4;
    localparam logic [2:0] OpRead   = 3'd5;
    localparam logic [2:0] OpStatus = 3'd6;
    localparam logic [2:0] OpIllegal = 3'd7;

    localparam logic [3:0] Settle = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            op_q;
    logic [num_bits-1:0]   data_q, imask_q;
    logic [num_bits-1:0]   comparand_q, cmp_mask_q;
    logic                  rsp_valid_q, rsp_any_q, rsp_err_q;
    logic [num_bits-1:0]   rsp_data_q;
    logic [num_bits-1:0]   status_word;
    logic                  accept;
    logic                  sample;

    assign accept = instr_valid && instr_ready;
    // WAIT -> RESP is the one cycle where the CAPP outputs are captured
    assign sample = (state_q == StWait) && (state_d == StResp);

`ifdef CAPP_SEQ_POPCOUNT_EN
    localparam int unsigned CntW = $clog2(num_cells + 1);
    logic [CntW-1:0] tag_count;

    // Population count of the tag vector
    always_comb begin
        tag_count = '0;
        for (int i = 0; i < int'(num_cells); i++) begin
            tag_count = tag_count + CntW'(tag_wires[i]);
        end
    end

    if (CntW <= num_bits) begin : g_zext
        assign status_word = num_bits'(tag_count);
    end else begin : g_sat
        assign status_word = (tag_count > CntW'({num_bits{1'b1}})) ? '1
                                                                   : tag_count[num_bits-1:0];
    end
`else
    assign status_word = '0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; settle counter is loaded on leaving ISSUE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    if (instr_op == OpIllegal) begin
                        state_d = StResp;
                    end else if (instr_op != OpNop) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = Settle;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = (op_q == OpRead || op_q == OpStatus) ? StResp : StIdle;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: ready in IDLE, one-hot strobes only during ISSUE
    always_comb begin
        instr_ready    = 1'b0;
        perform_search = 1'b0;
        set            = 1'b0;
        select_first   = 1'b0;
        write_lines    = '0;
        unique case (state_q)
            StIdle:  instr_ready = 1'b1;
            StIssue: begin
                case (op_q)
                    OpSearch: perform_search = 1'b1;
                    OpSet:    set            = 1'b1;
                    OpSelFst: select_first   = 1'b1;
                    OpWrite:  write_lines    = {~data_q & imask_q, data_q & imask_q};
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    // Command latch, comparand/mask registers and response registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q        <= OpNop;
            data_q      <= '0;
            imask_q     <= '0;
            comparand_q <= '0;
            cmp_mask_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_any_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= instr_op;
                data_q  <= instr_data;
                imask_q <= instr_mask;
                // Comparand is live during the search strobe and held until the next SEARCH
                if (instr_op == OpSearch) begin
                    comparand_q <= instr_data;
                    cmp_mask_q  <= instr_mask;
                end
                if (instr_op == OpIllegal) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_any_q   <= 1'b0;
                end
            end
            if (sample) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_any_q   <= |tag_wires;
                rsp_data_q  <= (op_q == OpRead) ? read_lines : status_word;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign comparand = comparand_q;
    assign mask      = cmp_mask_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_any   = rsp_any_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/capp_sequencer.md
Name: capp_sequencer

Overview:
- Command front-end sitting directly upstream of the CAPP array (compare/cells/tags).
- Accepts one micro-op at a time over a valid/ready handshake and drives the CAPP control inputs: comparand, mask, perform_search, set, select_first, write_lines.
- Waits a fixed settle time, then samples the CAPP outputs (tag_wires, read_lines) and returns results over a valid/ready response channel.

Parameters:
- num_bits, 32, CAPP word width
- num_cells, 100, number of CAPP cells/tags
- SETTLE_CYCLES, 2, cycles to wait after a CAPP strobe before sampling or accepting the next op (legal range 1..15)

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- instr_valid  input  1  command present
- instr_ready  output  1  sequencer can accept a command
- instr_op  input  3  opcode
- instr_data  input  num_bits  comparand / write data
- instr_mask  input  num_bits  bit mask, 1 = bit participates
- comparand  output  num_bits  to CAPP
- mask  output  num_bits  to CAPP
- perform_search  output  1  one-cycle search strobe
- set  output  1  one-cycle set-all-tags strobe
- select_first  output  1  one-cycle select-first strobe
- write_lines  output  2*num_bits  [i] = write 1 to bit i, [num_bits+i] = write 0 to bit i
- tag_wires  input  num_cells  from CAPP
- read_lines  input  num_bits  from CAPP
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  num_bits  read word, or status count
- rsp_any  output  1  at least one tag set at sample time
- rsp_err  output  1  illegal opcode

Behaviour:
- Reset (async, RST_N low): state = IDLE; all outputs 0 except instr_ready = 1; comparand and mask are cleared; any pending response is dropped. This also applies mid-operation.
- Opcodes: 0 NOP, 1 SEARCH, 2 SET, 3 SELFIRST, 4 WRITE, 5 READ, 6 STATUS, 7 illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - instr_ready = 1; a command is accepted when instr_valid && instr_ready.
  - NOP: stays in IDLE with no effect.
  - Opcode 7: goes to RESP with rsp_err = 1, rsp_data = 0, rsp_any = 0.
  - All other opcodes latch op/data/mask and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - SEARCH: comparand ← data and mask ← mask, both registered and held until the next SEARCH; perform_search = 1.
  - SET: set = 1.
  - SELFIRST: select_first = 1.
  - WRITE: write_lines[i] = data[i] & mask[i]; write_lines[num_bits+i] = ~data[i] & mask[i]. Driven for this cycle only, 0 otherwise.
  - READ, STATUS: no strobe.
  - All ops then go to WAIT with counter = SETTLE_CYCLES.
- WAIT:
  - Counter decrements each cycle.
  - At 0: READ/STATUS go to RESP; all others go to IDLE.
  - instr_ready = 0 throughout.
- RESP entry (one-cycle sample):
  - rsp_any = |tag_wires.
  - READ: rsp_data = read_lines.
  - STATUS: rsp_data = tag count (see Optional Feature).
  - rsp_valid = 1.
- RESP hold and exit:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, rsp_valid drops next cycle and the state returns to IDLE.
  - instr_ready = 0 in RESP; there is no overlap of command and response.
- Strobe guarantee: strobes are one-hot and single-cycle; perform_search, set, select_first and write_lines are never active in the same cycle.
- Latency:
  - Accept to strobe: 1 cycle.
  - Non-responding ops: accept to next instr_ready = SETTLE_CYCLES + 2 cycles.
  - Accept to rsp_valid: SETTLE_CYCLES + 2 cycles.
- STATUS count width: $clog2(num_cells+1) bits, zero-extended into num_bits. If num_bits is too narrow, the count saturates at 2^num_bits − 1.

Optional Feature:
- CAPP_SEQ_POPCOUNT_EN defined: STATUS returns rsp_data = population count of tag_wires, computed combinationally and registered on RESP entry.
- Undefined: STATUS returns rsp_data = 0, and only rsp_any is meaningful. No popcount logic is synthesized.

Test Plan:
- Reset: hold RST_N low for 3 cycles mid-WAIT of a SEARCH -> all strobes 0, rsp_valid 0, instr_ready 1, comparand and mask 0 immediately after RST_N falls.
- SEARCH (num_bits=8, SETTLE_CYCLES=2): op=1, data=0xA5, mask=0xF0 -> exactly one cycle of perform_search = 1 one cycle after accept; comparand = 0xA5 and mask = 0xF0 held afterwards; instr_ready returns 4 cycles after accept.
- WRITE: op=4, data=0x3C, mask=0x0F -> for one cycle write_lines[7:0] = 0x0C and write_lines[15:8] = 0x03; 0 before and after.
- READ with backpressure: read_lines = 0x5A, tag_wires = 0 -> rsp_valid 4 cycles after accept with rsp_data = 0x5A, rsp_any = 0. Hold rsp_ready low for 5 cycles -> outputs stable; instr_ready stays 0 until the handshake completes.
- STATUS (num_cells=4, tag_wires=4'b1011): with CAPP_SEQ_POPCOUNT_EN -> rsp_data = 3, rsp_any = 1; without it -> rsp_data = 0, rsp_any = 1.
- Illegal and NOP: op=7 -> rsp_valid next cycle with rsp_err = 1 and no strobes. op=0 back-to-back ×3 -> accepted every cycle, no strobes, no responses.
